permute_pipe: RTL and testbench

- Parametrised, pipelined successor of the single-cycle hypervector permute unit in the HPU datapath.
- Cyclically rotates a DIM-bit hypervector by a runtime amount, in either direction.
- Adds valid/ready handshaking with backpressure, configurable pipeline depth, and synchronous flush.
- Sits between the HV register file/encoder and the bind/bundle units, and accepts one vector per cycle when not stalled.

---
 rtl/permute_pipe.sv | 161 ++++++++++++++++
 tb/tb_permute_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/permute_pipe.sv
// rtl/permute_pipe.sv - pipelined cyclic rotate of a DIM-bit hypervector with valid/ready handshake
//
// Rotates in_data right (in_dir=0) or left (in_dir=1) by in_amount. The rotation
// is built from log2(DIM) binary stages. A pipeline register follows every
// REG_EVERY stages and always follows the final stage.
//
// Optional feature: define PERMUTE_TAG_EN to carry a TAG_W-bit sideband tag
// (in_tag -> out_tag) alongside the data through every pipeline register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of every pipeline valid bit
//   in_valid/in_ready     input handshake
//   in_data/in_amount     vector and rotate amount N
//   in_dir                0 = rotate right (permute), 1 = rotate left (inverse)
//   out_valid/out_ready   output handshake
//   out_data              rotated vector
//   in_tag/out_tag        sideband tag (PERMUTE_TAG_EN only)
//   busy                  any pipeline register holds a vector
module permute_pipe #(
    parameter int DIM       = 1024,
    parameter int REG_EVERY = 5,
    parameter int TAG_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIM-1:0]          in_data,
    input  logic [$clog2(DIM)-1:0]  in_amount,
    input  logic                    in_dir,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIM-1:0]          out_data,
`ifdef PERMUTE_TAG_EN
    input  logic [TAG_W-1:0]        in_tag,
    output logic [TAG_W-1:0]        out_tag,
`endif
    output logic                    busy
);

    localparam int S = $clog2(DIM);
    localparam int P = (S + REG_EVERY - 1) / REG_EVERY;

    if (DIM < 4 || (DIM & (DIM - 1)) != 0) begin : g_bad_dim
        $error("permute_pipe: DIM must be a power of two >= 4");
    end
    if (REG_EVERY < 1 || REG_EVERY > S) begin : g_bad_reg_every
        $error("permute_pipe: REG_EVERY must be in 1..log2(DIM)");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $error("permute_pipe: TAG_W must be at least 1");
    end

    // Apply the binary rotate-right stages lo..hi-1 selected by the amount bits.
    function automatic logic [DIM-1:0] rot_stages(input logic [DIM-1:0] d,
                                                  input logic [S-1:0]   a,
                                                  input int             lo,
                                                  input int             hi);
        logic [DIM-1:0] r;
        r = d;
        for (int k = 0; k < S; k++) begin
            if (k >= lo && k < hi && a[k]) begin
                r = (r >> (1 << k)) | (r << (DIM - (1 << k)));
            end
        end
        return r;
    endfunction

    // A left rotate by N equals a right rotate by (DIM-N) mod DIM; the S-bit
    // two's complement wraps N=0 back to 0, so every stage rotates right only.
    logic [S-1:0] amt_eff;
    assign amt_eff = in_dir ? (~in_amount + 1'b1) : in_amount;

    logic [P-1:0] valid_vec;

    for (genvar j = 0; j < P; j++) begin : g_rg
        localparam int LO = j * REG_EVERY;
        localparam int HI = (LO + REG_EVERY < S) ? (LO + REG_EVERY) : S;

        logic [DIM-1:0] d_src;
        logic [S-1:0]   a_src;
        logic           v_src;
        logic [DIM-1:0] data_q;
        logic           valid_q;
        logic           load;
`ifdef PERMUTE_TAG_EN
        logic [TAG_W-1:0] t_src;
        logic [TAG_W-1:0] tag_q;
`endif

        if (j == 0) begin : g_src
            assign d_src = in_data;
            assign a_src = amt_eff;
            assign v_src = in_valid;
`ifdef PERMUTE_TAG_EN
            assign t_src = in_tag;
`endif
        end else begin : g_src
            assign d_src = g_rg[j-1].data_q;
            assign a_src = g_rg[j-1].g_amt.amt_q;
            assign v_src = g_rg[j-1].valid_q;
`ifdef PERMUTE_TAG_EN
            assign t_src = g_rg[j-1].tag_q;
`endif
        end

        // A register may load when empty or when its content moves on this
        // cycle; the chain resolves combinationally back to the input.
        if (j == P - 1) begin : g_load
            assign load = !valid_q || out_ready;
        end else begin : g_load
            assign load = !valid_q || g_rg[j+1].load;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
`ifdef PERMUTE_TAG_EN
                tag_q   <= '0;
`endif
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= v_src;
                if (v_src) begin
                    data_q <= rot_stages(d_src, a_src, LO, HI);
`ifdef PERMUTE_TAG_EN
                    tag_q  <= t_src;
`endif
                end
            end
        end

        // The amount only matters to later stages, so the last register has none.
        if (j < P - 1) begin : g_amt
            logic [S-1:0] amt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    amt_q <= '0;
                end else if (!flush && load && v_src) begin
                    amt_q <= a_src;
                end
            end
        end

        assign valid_vec[j] = valid_q;
    end

    // flush wins over a simultaneous input, so the input is refused.
    assign in_ready  = !flush && g_rg[0].load;
    assign out_valid = g_rg[P-1].valid_q;
    assign out_data  = g_rg[P-1].data_q;
`ifdef PERMUTE_TAG_EN
    assign out_tag   = g_rg[P-1].tag_q;
`endif
    assign busy      = |valid_vec;

endmodule

// File: tb/tb_permute_pipe.sv
// tb/tb_permute_pipe.sv - self-checking bench for permute_pipe
`timescale 1ns/1ps
module tb_permute_pipe;

    localparam int DIM       = 1024;
    localparam int REG_EVERY = 5;
    localparam int TAG_W     = 8;
    localparam int AW        = $clog2(DIM);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [DIM-1:0]  in_data;
    logic [AW-1:0]   in_amount;
    logic            in_dir;
    logic            out_valid;
    logic            out_ready;
    logic [DIM-1:0]  out_data;
    logic            busy;
`ifdef PERMUTE_TAG_EN
    logic [TAG_W-1:0] in_tag;
    logic [TAG_W-1:0] out_tag;
    logic [TAG_W-1:0] tag_ctr;
    logic [TAG_W-1:0] tag_sb[$];
`endif

    permute_pipe #(.DIM(DIM), .REG_EVERY(REG_EVERY), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PERMUTE_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DIM-1:0] sb[$];
    logic [DIM-1:0] mexp;
    logic rand_ready = 1'b0;

    typedef struct {
        logic [DIM-1:0] data;
        int             amt;
        logic           dir;
        logic [DIM-1:0] exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [DIM-1:0] act, input logic [DIM-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got[127:0]=%h expected[127:0]=%h (vectors differ)", name, act[127:0], exp[127:0]);
        end
    endtask

    // Reference: index-by-index definition of the permutation.
    function automatic logic [DIM-1:0] ref_rot(input logic [DIM-1:0] d, input int n, input logic dir);
        logic [DIM-1:0] r;
        int src;
        for (int i = 0; i < DIM; i++) begin
            src  = dir ? ((i - n + DIM) % DIM) : ((i + n) % DIM);
            r[i] = d[src];
        end
        return r;
    endfunction

    function automatic logic [DIM-1:0] rand_vec();
        logic [DIM-1:0] v;
        for (int w = 0; w < DIM / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [DIM-1:0] one_hot(input int b);
        logic [DIM-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // Drive one vector, wait for acceptance, then record its expected result.
    task automatic send(input logic [DIM-1:0] d, input int n, input logic dir, input logic [DIM-1:0] exp);
        int   guard;
        logic ok;
        guard     = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = AW'(n);
        in_dir    = dir;
`ifdef PERMUTE_TAG_EN
        in_tag    = tag_ctr;
`endif
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            guard++;
        end while (!ok && guard < 200);
        if (ok) begin
            sb.push_back(exp);
`ifdef PERMUTE_TAG_EN
            tag_sb.push_back(tag_ctr);
            tag_ctr = tag_ctr + 1'b1;
`endif
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_valid=1 expected no output");
            end else begin
                mexp = sb.pop_front();
                chk_vec("sb_data", out_data, mexp);
`ifdef PERMUTE_TAG_EN
                chk("sb_tag", out_tag, tag_sb.pop_front());
`endif
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    logic [DIM-1:0] bp_d[4];
    logic [DIM-1:0] bp_e[4];
    int             bp_n[4];
    logic [DIM-1:0] d, r;
    int             n, idx, acc;
    logic           ok;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amount = '0;
        in_dir    = 1'b0;
        out_ready = 1'b1;
`ifdef PERMUTE_TAG_EN
        in_tag    = '0;
        tag_ctr   = '0;
`endif
        void'($urandom(32'hC0FFEE01));

        tbl[0] = '{data: one_hot(0), amt: 513, dir: 1'b0, exp: one_hot(511)};
        tbl[1] = '{data: one_hot(0), amt: 513, dir: 1'b1, exp: one_hot(513)};
        tbl[2] = '{data: one_hot(0), amt: 0,   dir: 1'b0, exp: one_hot(0)};
        tbl[3] = '{data: one_hot(0), amt: 0,   dir: 1'b1, exp: one_hot(0)};
        tbl[4] = '{data: one_hot(5), amt: 1023, dir: 1'b0, exp: one_hot(6)};
        tbl[5] = '{data: one_hot(1023), amt: 1, dir: 1'b1, exp: one_hot(0)};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk_vec("rst_out_data", out_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Latency: result appears exactly two cycles after acceptance, for one cycle
        send(one_hot(0), 1, 1'b0, one_hot(1023));
        @(negedge clk); chk("lat_c1_valid", out_valid, 0);
        @(negedge clk); chk("lat_c2_valid", out_valid, 1);
        @(negedge clk); chk("lat_c3_valid", out_valid, 0);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 6; i++) send(tbl[i].data, tbl[i].amt, tbl[i].dir, tbl[i].exp);
        drain();
        @(posedge clk); #1;

        // Random rotations and round trips under random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            d = rand_vec();
            n = $urandom_range(0, DIM - 1);
            r = ref_rot(d, n, 1'b0);
            send(d, n, 1'b0, r);
            send(r, n, 1'b1, d);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();
        @(posedge clk); #1;

        // Stall with four back-to-back vectors, then release
        for (int k = 0; k < 4; k++) begin
            bp_d[k] = rand_vec();
            bp_n[k] = $urandom_range(1, DIM - 1);
            bp_e[k] = ref_rot(bp_d[k], bp_n[k], k[0]);
        end
        idx       = 0;
        acc       = 0;
        in_valid  = 1'b1;
        in_data   = bp_d[0];
        in_amount = AW'(bp_n[0]);
        in_dir    = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 6);
            @(negedge clk);
            if (cyc == 3 || cyc == 5) begin
                chk("bp_in_ready", in_ready, 0);
                chk("bp_accepted", acc, 2);
                chk("bp_out_valid", out_valid, 1);
                chk_vec("bp_hold_data", out_data, bp_e[0]);
            end
            if (cyc >= 6 && cyc <= 9) chk("bp_stream_valid", out_valid, 1);
            if (cyc == 10) chk("bp_stream_end", out_valid, 0);
            ok = in_valid && in_ready;
            @(posedge clk); #1;
            if (ok) begin
                sb.push_back(bp_e[idx]);
`ifdef PERMUTE_TAG_EN
                tag_sb.push_back(tag_ctr);
                tag_ctr = tag_ctr + 1'b1;
                in_tag  = tag_ctr;
`endif
                acc++;
                idx++;
                if (idx == 4) begin
                    in_valid = 1'b0;
                end else begin
                    in_data   = bp_d[idx];
                    in_amount = AW'(bp_n[idx]);
                    in_dir    = idx[0];
                end
            end
        end
        chk("bp_total_accepted", acc, 4);
        drain();
        @(posedge clk); #1;

        // Flush with two held vectors and a simultaneous input
        out_ready = 1'b0;
        send(rand_vec(), 3, 1'b0, '0);
        send(rand_vec(), 7, 1'b1, '0);
        in_valid = 1'b1;
        in_data  = rand_vec();
        flush    = 1'b1;
        @(negedge clk);
        chk("fl_in_ready_during", in_ready, 0);
        chk("fl_busy_before", busy, 1);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_busy_after", busy, 0);
        chk("fl_out_valid_after", out_valid, 0);
        chk("fl_in_ready_after", in_ready, 1);
        sb.delete();
`ifdef PERMUTE_TAG_EN
        tag_sb.delete();
`endif
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("fl_nothing_accepted", busy, 0);
        @(posedge clk); #1;

        // Asynchronous reset with two vectors in flight
        out_ready = 1'b0;
`ifdef PERMUTE_TAG_EN
        tag_ctr = 8'h5A;
`endif
        send(rand_vec(), 11, 1'b0, '0);
`ifdef PERMUTE_TAG_EN
        tag_ctr = 8'hA5;
`endif
        send(rand_vec(), 22, 1'b1, '0);
        @(negedge clk);
        chk("ar_busy_before", busy, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk_vec("ar_out_data", out_data, '0);
        chk("ar_busy", busy, 0);
`ifdef PERMUTE_TAG_EN
        chk("ar_out_tag", out_tag, 0);
        tag_sb.delete();
`endif
        sb.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("ar_no_output", out_valid, 0);
        end

        chk("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
